// File: rtl/alu_pkg.sv
// Shared ALU op codes and execute-stage state encoding.
// Used by the ALU decoder and by alu_iterative_exec.
package alu_pkg;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SLL  = 3'b001;
    localparam logic [2:0] ALU_SLT  = 3'b010;
    localparam logic [2:0] ALU_SLTU = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SR   = 3'b101;
    localparam logic [2:0] ALU_OR   = 3'b110;
    localparam logic [2:0] ALU_AND  = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } alu_state_t;

    function automatic logic is_shift_op(input logic [2:0] op);
        return (op == ALU_SLL) || (op == ALU_SR);
    endfunction

endpackage

// File: rtl/alu_single_op.sv
// Combinational single-cycle ALU result for all non-shift ops.
// Shift codes return zero; the caller supplies shift results.
module alu_single_op
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       op,
    input  logic             funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result
);

    logic lt_s;
    logic lt_u;

    assign lt_s = $signed(a) < $signed(b);
    assign lt_u = a < b;

    always_comb begin
        result = '0;
        unique case (op)
            ALU_ADD:  result = funct ? (a - b) : (a + b);
            ALU_SLT:  result = {{(WIDTH-1){1'b0}}, lt_s};
            ALU_SLTU: result = {{(WIDTH-1){1'b0}}, lt_u};
            ALU_XOR:  result = a ^ b;
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/alu_iterative_exec.sv
// Execute-stage ALU with valid/ready handshake; shifts run one bit per cycle.
// Define ALU_FAST_SHIFT_EN to use a single-cycle barrel shifter instead.
module alu_iterative_exec
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             in_clk,
    input  logic             in_rst,
    input  logic             in_valid,
    output logic             out_ready,
    input  logic [2:0]       in_alu_control,
    input  logic             in_funct_control,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             in_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_busy
);

    alu_state_t         state;
    alu_state_t         state_nxt;
    logic               accept;
    logic               is_shift;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   single_res;
    logic [WIDTH-1:0]   result_nxt;
    logic               load_result;

    assign accept    = in_valid && out_ready;
    assign is_shift  = is_shift_op(in_alu_control);
    assign shamt     = in_b[SHAMT_W-1:0];
    assign out_ready = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out_busy  = (state != IDLE);

    alu_single_op #(.WIDTH(WIDTH)) u_single (
        .op     (in_alu_control),
        .funct  (in_funct_control),
        .a      (in_a),
        .b      (in_b),
        .result (single_res)
    );

`ifdef ALU_FAST_SHIFT_EN
    logic [WIDTH-1:0] barrel_res;

    assign barrel_res = (in_alu_control == ALU_SLL) ? (in_a << shamt) :
                        in_funct_control ? WIDTH'($signed(in_a) >>> shamt) :
                        (in_a >> shamt);
`else
    logic [WIDTH-1:0]   work;
    logic [WIDTH-1:0]   work_step;
    logic [SHAMT_W-1:0] cnt;
    logic               op_left;
    logic               op_arith;
    logic               load_work;

    // SRA fill: the MSB of the working register keeps the captured sign bit
    assign work_step = op_left ? {work[WIDTH-2:0], 1'b0} :
                       {op_arith & work[WIDTH-1], work[WIDTH-1:1]};
`endif

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        load_result = 1'b0;
        result_nxt  = single_res;
`ifndef ALU_FAST_SHIFT_EN
        load_work   = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (accept) begin
`ifdef ALU_FAST_SHIFT_EN
                    state_nxt   = DONE;
                    load_result = 1'b1;
                    if (is_shift) result_nxt = barrel_res;
`else
                    if (is_shift && shamt != '0) begin
                        state_nxt = SHIFT;
                        load_work = 1'b1;
                    end else begin
                        state_nxt   = DONE;
                        load_result = 1'b1;
                        if (is_shift) result_nxt = in_a;
                    end
`endif
                end
            end
`ifndef ALU_FAST_SHIFT_EN
            SHIFT: begin
                if (cnt == SHAMT_W'(1)) begin
                    state_nxt   = DONE;
                    load_result = 1'b1;
                    result_nxt  = work_step;
                end
            end
`endif
            DONE: begin
                if (in_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            out_result <= '0;
            out_zero   <= 1'b0;
        end else if (load_result) begin
            out_result <= result_nxt;
            out_zero   <= (result_nxt == '0);
        end
    end

`ifndef ALU_FAST_SHIFT_EN
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            work     <= '0;
            cnt      <= '0;
            op_left  <= 1'b0;
            op_arith <= 1'b0;
        end else if (load_work) begin
            work     <= in_a;
            cnt      <= shamt;
            op_left  <= (in_alu_control == ALU_SLL);
            op_arith <= in_funct_control;
        end else if (state == SHIFT) begin
            work <= work_step;
            cnt  <= cnt - SHAMT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_alu_iterative_exec.sv
// Directed-vector bench for alu_iterative_exec (default iterative build).
// Latency is counted in cycles from the accept edge to out_valid.
module tb_alu_iterative_exec;
    import alu_pkg::*;

    logic        in_clk;
    logic        in_rst;
    logic        in_valid;
    logic        out_ready;
    logic [2:0]  in_alu_control;
    logic        in_funct_control;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        in_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic        out_busy;

    int n_tests = 0;
    int n_fail  = 0;

    alu_iterative_exec #(.WIDTH(32)) dut (
        .in_clk           (in_clk),
        .in_rst           (in_rst),
        .in_valid         (in_valid),
        .out_ready        (out_ready),
        .in_alu_control   (in_alu_control),
        .in_funct_control (in_funct_control),
        .in_a             (in_a),
        .in_b             (in_b),
        .out_valid        (out_valid),
        .in_ready         (in_ready),
        .out_result       (out_result),
        .out_zero         (out_zero),
        .out_busy         (out_busy)
    );

    initial begin
        in_clk = 1'b0;
        forever #5 in_clk = ~in_clk;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one request, wait for out_valid and check result/zero/latency.
    // With in_ready high the result drains on the next edge.
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp,
                          input int exp_lat);
        int lat;
        @(negedge in_clk);
        chk({tag, "_ready"}, 32'(out_ready), 32'd1);
        in_valid         = 1'b1;
        in_alu_control   = op;
        in_funct_control = f;
        in_a             = a;
        in_b             = b;
        @(posedge in_clk);
        #1;
        in_valid = 1'b0;
        in_a     = 32'hDEAD_BEEF;
        in_b     = 32'h0000_0003;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge in_clk);
            #1;
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_res"}, out_result, exp);
        chk({tag, "_zero"}, 32'(out_zero), 32'(exp == 32'd0));
        if (in_ready) begin
            @(posedge in_clk);
            #1;
            chk({tag, "_drain"}, 32'(out_valid), 32'd0);
        end
    endtask

    initial begin
        in_rst           = 1'b1;
        in_valid         = 1'b0;
        in_ready         = 1'b1;
        in_alu_control   = ALU_ADD;
        in_funct_control = 1'b0;
        in_a             = '0;
        in_b             = '0;
        #12;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_result", out_result, 32'd0);
        chk("rst_zero", 32'(out_zero), 32'd0);
        chk("rst_busy", 32'(out_busy), 32'd0);
        chk("rst_ready", 32'(out_ready), 32'd1);
        @(negedge in_clk);
        in_rst = 1'b0;

        run_op("add_wrap", ALU_ADD,  1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1);
        run_op("sub",      ALU_ADD,  1'b1, 32'd5, 32'd7, 32'hFFFF_FFFE, 1);
        run_op("slt",      ALU_SLT,  1'b0, 32'hFFFF_FFFF, 32'd1, 32'd1, 1);
        run_op("sltu",     ALU_SLTU, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1);
        run_op("xor",      ALU_XOR,  1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00,
               32'h0FF0_0FF0, 1);
        run_op("xor_f1",   ALU_XOR,  1'b1, 32'hF0F0_F0F0, 32'hFF00_FF00,
               32'h0FF0_0FF0, 1);
        run_op("or",       ALU_OR,   1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00,
               32'hFFF0_FFF0, 1);
        run_op("and",      ALU_AND,  1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00,
               32'hF000_F000, 1);
        run_op("sra4",     ALU_SR,   1'b1, 32'h8000_0000, 32'd4,
               32'hF800_0000, 5);
        run_op("srl4",     ALU_SR,   1'b0, 32'h8000_0000, 32'd4,
               32'h0800_0000, 5);
        run_op("sll31",    ALU_SLL,  1'b0, 32'd1, 32'd31, 32'h8000_0000, 32);
        run_op("sra1",     ALU_SR,   1'b1, 32'h8000_0001, 32'd1,
               32'hC000_0000, 2);
        run_op("sll_f1",   ALU_SLL,  1'b1, 32'd3, 32'd1, 32'd6, 2);
        run_op("srl_sh0",  ALU_SR,   1'b0, 32'h1234_5678, 32'h0000_0020,
               32'h1234_5678, 1);
        run_op("sll_sh0",  ALU_SLL,  1'b0, 32'h1234_5678, 32'h0000_0020,
               32'h1234_5678, 1);

        // Backpressure: result held for 3 cycles, stray request ignored
        in_ready = 1'b0;
        run_op("bp", ALU_ADD, 1'b0, 32'd10, 32'd20, 32'd30, 1);
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                @(negedge in_clk);
                in_valid       = 1'b1;
                in_alu_control = ALU_ADD;
                in_a           = 32'd100;
                in_b           = 32'd100;
            end
            @(posedge in_clk);
            #1;
            in_valid = 1'b0;
            chk("bp_hold_res", out_result, 32'd30);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_ready", 32'(out_ready), 32'd0);
        end
        @(negedge in_clk);
        in_ready = 1'b1;
        @(posedge in_clk);
        #1;
        chk("bp_drain_valid", 32'(out_valid), 32'd0);
        chk("bp_drain_ready", 32'(out_ready), 32'd1);
        chk("bp_drain_res", out_result, 32'd30);
        @(posedge in_clk);
        #1;
        chk("bp_no_stray", 32'(out_busy), 32'd0);

        // Reset mid-shift
        @(negedge in_clk);
        in_valid       = 1'b1;
        in_alu_control = ALU_SLL;
        in_a           = 32'd1;
        in_b           = 32'd31;
        @(posedge in_clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge in_clk);
        #3;
        chk("mid_busy", 32'(out_busy), 32'd1);
        in_rst = 1'b1;
        #1;
        chk("mrst_valid", 32'(out_valid), 32'd0);
        chk("mrst_busy", 32'(out_busy), 32'd0);
        chk("mrst_ready", 32'(out_ready), 32'd1);
        chk("mrst_result", out_result, 32'd0);
        @(negedge in_clk);
        in_rst = 1'b0;
        run_op("post_rst_add", ALU_ADD, 1'b0, 32'd2, 32'd3, 32'd5, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_iterative_exec.md
Name: alu_iterative_exec

Overview:
- Execution-side consumer of the ALU control word produced by the ALU decoder.
- Takes a 3-bit ALU control code, a funct modifier bit and two operands over a valid/ready handshake, and returns a result plus a zero flag.
- Logic and arithmetic ops complete in one cycle. Shifts run iteratively, one bit per cycle.
- First step toward the multi-cycle core. It replaces the purely combinational ALU on the execute stage.

Parameters:
- WIDTH, 32, operand/result width in bits. Must be a power of 2 and at least 8.
- SHAMT_W, $clog2(WIDTH), shift-amount width. Derived; not overridden.

Ports:
- in_clk  input  1  clock; all state changes on the rising edge.
- in_rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  request valid.
- out_ready  output  1  block can accept a request (high only in IDLE).
- in_alu_control  input  3  op code: 000 ADD/SUB, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA, 110 OR, 111 AND.
- in_funct_control  input  1  modifier: selects SUB for 000 and SRA for 101; ignored for all other codes.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B. Bits [SHAMT_W-1:0] give the shift amount.
- out_valid  output  1  result valid.
- in_ready  input  1  downstream accepts the result.
- out_result  output  WIDTH  result.
- out_zero  output  1  high when out_result == 0. Meaningful only while out_valid is high.
- out_busy  output  1  high when the state is not IDLE.

Behaviour:
- Reset values: out_valid=0, out_result=0, out_zero=0, out_busy=0, out_ready=1. State goes to IDLE.
- Accept occurs when in_valid && out_ready at a rising edge. The op, modifier, operands and shamt are captured at that edge; later input changes are ignored.
- States:
  - IDLE: on accept of a non-shift op, or a shift with shamt=0, compute the result and go to DONE. On accept of a shift with shamt>0, load the working register with in_a and the counter with shamt, then go to SHIFT.
  - SHIFT: each cycle, shift the working register by 1 and decrement the counter. When the counter reaches 1, the final step is written to out_result and the state goes to DONE. SLL fills with 0. SRL fills with 0. SRA fills with the captured bit WIDTH-1.
  - DONE: out_valid=1. When in_ready is high, go to IDLE and drop out_valid the next cycle. While in_ready is low, out_result and out_zero hold stable and no new request is accepted.
- Latency from accept edge to out_valid high:
  - 1 cycle for all non-shift ops and for shamt=0.
  - 1+shamt cycles for shifts. The maximum is WIDTH cycles.
- Throughput: one request per (latency + 1) cycles at best, because out_ready is asserted only in IDLE.
- Arithmetic:
  - ADD and SUB wrap modulo 2^WIDTH; no overflow flag.
  - SLT compares signed; SLTU compares unsigned. The result is 1 or 0, zero-extended.
  - Bits of in_b above SHAMT_W-1 are ignored for shifts.
- Reset asserted mid-operation, in any state, aborts the operation immediately (asynchronously) and forces the reset values. No partial result is ever presented.
- An undefined modifier combination (funct_control=1 with an op other than 000 or 101) is treated as the base op.

Optional Feature:
- Macro: ALU_FAST_SHIFT_EN.
- When defined: shifts use a single-cycle barrel shifter, the SHIFT state and counter are not built, and all ops have 1-cycle latency.
- When undefined: shifts are iterative as described above.
- The handshake and output timing for non-shift ops are identical in both builds.

Decomposition:
- Shared package alu_pkg holds:
  - the op-code constants ALU_ADD=000, ALU_SLL=001, ALU_SLT=010, ALU_SLTU=011, ALU_XOR=100, ALU_SR=101, ALU_OR=110, ALU_AND=111. These are shared with the decoder so both ends agree.
  - the state encoding IDLE, SHIFT and DONE.
- One sub-module: alu_single_op, the combinational single-cycle result for non-shift ops. It is reused by the later pipelined core.

Test Plan:
- ADD with a=0xFFFFFFFF, b=0x00000001, funct=0: result 0x00000000, out_zero=1, out_valid high 1 cycle after accept.
- SUB (funct=1) with a=5, b=7: result 0xFFFFFFFE, out_zero=0. Then SLT with a=0xFFFFFFFF, b=1 gives 1, and SLTU with the same operands gives 0.
- SRA (funct=1) with a=0x80000000, b=4: result 0xF8000000 after 5 cycles. SRL with the same operands gives 0x08000000. SLL with a=1, b=31 gives 0x80000000 after 32 cycles.
- Shift with shamt=0 and b=0x00000020: result equals a after 1 cycle, showing the upper bits of b are ignored.
- Backpressure: hold in_ready low for 3 cycles after out_valid. Result stays stable and out_ready stays 0. A new in_valid pulse is ignored. The result drains on the first cycle with in_ready high, and out_ready returns 1 the next cycle.
- Assert in_rst 10 cycles into an SLL with shamt=31: out_valid=0, out_busy=0, out_ready=1 immediately. After reset release, an ADD 2+3 returns 5.
